// File: rtl/core_pkg.sv
// core_pkg: shared widths, register address and writeback request types
package core_pkg;
  localparam int XLEN = 32;
  localparam int RAW = 5;
  localparam int NREG = 2 ** RAW;
  typedef logic [RAW-1:0] reg_addr_t;
  typedef struct packed {
    reg_addr_t dest;
    logic [XLEN-1:0] data;
  } wb_req_t;
  function automatic logic [NREG-1:0] onehot(input reg_addr_t a);
    return {{(NREG-1){1'b0}}, 1'b1} << a;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests with full/empty flags
module wb_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t push_data,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wb_req_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_d = rst ? '0 : wr_q + AW'(push);
    rd_d = rst ? '0 : rd_q + AW'(pop);
    cnt_d = rst ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  // pointer and occupancy state
  always_ff @(posedge clk) begin
    wr_q <= wr_d;
    rd_q <= rd_d;
    cnt_q <= cnt_d;
  end
  // storage needs no reset; occupancy alone decides validity
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= push_data;
  end
  assign head = mem_q[rd_q];
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline and MDU writebacks and tracks pending MDU destinations
module wb_arbiter
  import core_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_wb_en,
  input  logic [RAW-1:0]  pipe_wb_dest,
  input  logic [XLEN-1:0] pipe_wb_data,
  output logic            wb_hold,
  input  logic            mdu_issue,
  input  logic [RAW-1:0]  mdu_issue_dest,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [RAW-1:0]  mdu_dest,
  input  logic [XLEN-1:0] mdu_data,
  input  logic [RAW-1:0]  rs1_addr,
  input  logic [RAW-1:0]  rs2_addr,
  input  logic [RAW-1:0]  rd_addr,
  output logic            hazard_stall,
  output logic            rg_wrt_en,
  output logic [RAW-1:0]  rg_wrt_dest,
  output logic [XLEN-1:0] rg_wrt_data
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  wb_req_t head;
  logic full, empty, push, pop, pipe_c, starved;
  logic [SW-1:0] starve_q, starve_d;
  logic [NREG-1:0] pend_q, pend_d;
  logic en_q, en_d;
  reg_addr_t dest_q, dest_d;
  logic [XLEN-1:0] data_q, data_d;
  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .push_data('{dest: mdu_dest, data: mdu_data}),
    .head(head),
    .full(full),
    .empty(empty)
  );
  assign mdu_ready = !full && !rst;
  // x0 results are accepted but never buffered; the register file does not guard x0
  assign push = mdu_valid && mdu_ready && mdu_dest != '0;
  assign pipe_c = pipe_wb_en && pipe_wb_dest != '0;
  assign starved = !empty && starve_q == SW'(STARVE_MAX);
  assign pop = !empty && (starved || !pipe_c);
  assign wb_hold = starved && pipe_wb_en && !rst;
  assign hazard_stall = pend_q[rs1_addr] | pend_q[rs2_addr] | pend_q[rd_addr];
  // arbitration, starvation counter, scoreboard (set beats clear) and output register
  always_comb begin
    starve_d = (rst || empty || pop) ? '0 : starve_q == SW'(STARVE_MAX) ? starve_q : starve_q + 1'b1;
    pend_d = rst ? '0 : ((pend_q & ~(pop ? onehot(head.dest) : '0))
           | ((mdu_issue && mdu_issue_dest != '0) ? onehot(mdu_issue_dest) : '0)) & ~NREG'(1);
    en_d = !rst && (pipe_c || !empty);
    dest_d = rst ? '0 : pop ? head.dest : pipe_c ? pipe_wb_dest : dest_q;
    data_d = rst ? '0 : pop ? head.data : pipe_c ? pipe_wb_data : data_q;
  end
  // registered state
  always_ff @(posedge clk) begin
    starve_q <= starve_d;
    pend_q <= pend_d;
    en_q <= en_d;
    dest_q <= dest_d;
    data_q <= data_d;
  end
  assign rg_wrt_en = en_q;
  assign rg_wrt_dest = dest_q;
  assign rg_wrt_data = data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized scoreboard bench against a queue-based reference model
module tb_wb_arbiter;
  import core_pkg::*;
  localparam int FD = 2;
  localparam int SM = 4;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1;
  logic pipe_wb_en = 0, mdu_issue = 0, mdu_valid = 0;
  logic [4:0] pipe_wb_dest = 0, mdu_issue_dest = 0, mdu_dest = 0, rs1_addr = 0, rs2_addr = 0, rd_addr = 0;
  logic [31:0] pipe_wb_data = 0, mdu_data = 0;
  logic wb_hold, mdu_ready, hazard_stall, rg_wrt_en;
  logic [4:0] rg_wrt_dest;
  logic [31:0] rg_wrt_data;
  wb_arbiter #(.FIFO_DEPTH(FD), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_wb_dest(pipe_wb_dest), .pipe_wb_data(pipe_wb_data),
    .wb_hold(wb_hold),
    .mdu_issue(mdu_issue), .mdu_issue_dest(mdu_issue_dest),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_dest(mdu_dest), .mdu_data(mdu_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .hazard_stall(hazard_stall),
    .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data)
  );
  int total = 0, bad = 0;
  typedef struct {bit en; bit [4:0] dest; bit [31:0] data;} wr_t;
  typedef struct {bit [4:0] dest; bit [31:0] data;} ent_t;
  wr_t exp_q[$];
  ent_t mq[$];
  int blk = 0;
  bit [31:0] pend = 0;
  bit [4:0] ld = 0;
  bit [31:0] ldat = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // monitor: every cycle's register-file write is compared with the queued expectation
  initial forever begin
    wr_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rg_wrt_en", rg_wrt_en, e.en);
      chk("rg_wrt_dest", rg_wrt_dest, e.dest);
      chk("rg_wrt_data", rg_wrt_data, e.data);
    end
  end
  task automatic cyc(input bit r, input bit pe, input bit [4:0] pd, input bit [31:0] pdat,
                     input bit mv, input bit [4:0] md, input bit [31:0] mdat,
                     input bit iss, input bit [4:0] idst,
                     input bit [4:0] a1, input bit [4:0] a2, input bit [4:0] a3,
                     output bit acc, output bit hold);
    bit pc, fw, rdy;
    int n;
    ent_t h;
    @(negedge clk);
    rst = r; pipe_wb_en = pe; pipe_wb_dest = pd; pipe_wb_data = pdat;
    mdu_valid = mv; mdu_dest = md; mdu_data = mdat; mdu_issue = iss; mdu_issue_dest = idst;
    rs1_addr = a1; rs2_addr = a2; rd_addr = a3;
    #1;
    n = mq.size();
    rdy = !r && n < FD;
    pc = pe && pd != 0;
    fw = n > 0 && (blk == SM || !pc);
    hold = !r && n > 0 && blk == SM && pe;
    chk("mdu_ready", mdu_ready, rdy);
    if (!r) begin
      chk("wb_hold", wb_hold, hold);
      chk("hazard_stall", hazard_stall, pend[a1] | pend[a2] | pend[a3]);
    end
    acc = mv && rdy;
    if (r) begin
      mq.delete(); blk = 0; pend = 0; ld = 0; ldat = 0;
      exp_q.push_back('{0, 0, 0});
    end else begin
      if (fw) begin
        h = mq.pop_front();
        pend[h.dest] = 0;
        ld = h.dest; ldat = h.data;
      end else if (pc) begin
        ld = pd; ldat = pdat;
      end
      exp_q.push_back('{fw || pc, ld, ldat});
      blk = (fw || n == 0) ? 0 : (blk < SM ? blk + 1 : blk);
      if (iss && idst != 0) pend[idst] = 1;
      if (acc && md != 0) mq.push_back('{md, mdat});
    end
  endtask
  task automatic idle(input int k);
    bit a, h;
    repeat (k) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a, h);
  endtask
  initial begin
    bit acc, hd, pe, mv, r;
    bit [4:0] pd, md;
    bit [31:0] pdat, mdat;
    int k;
    repeat (3) cyc(1, 0, 0, 0, 1, 7, 5, 0, 0, 0, 0, 0, acc, hd);
    idle(1);
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, acc, hd);
    cyc(0, 1, 0, 32'h1111, 0, 0, 0, 0, 0, 0, 0, 0, acc, hd);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, acc, hd);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, acc, hd);
    cyc(0, 0, 0, 0, 1, 7, 32'h12, 0, 0, 7, 0, 0, acc, hd);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, acc, hd);
    cyc(0, 1, 4, 32'h1234, 1, 9, 32'hAA, 0, 0, 0, 0, 0, acc, hd);
    repeat (7) cyc(0, 1, 4, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, acc, hd);
    idle(1);
    k = 10;
    repeat (14) begin
      cyc(0, 1, 6, 32'h66, k < 13, 5'(k), 32'(k), 0, 0, 0, 0, 0, acc, hd);
      if (acc) k++;
    end
    idle(4);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, acc, hd);
    cyc(0, 0, 0, 0, 1, 3, 32'h33, 0, 0, 3, 0, 0, acc, hd);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0, 0, acc, hd);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, acc, hd);
    hd = 0; acc = 0; mv = 0; md = 0; mdat = 0; pe = 0; pd = 0; pdat = 0;
    repeat (3000) begin
      if (!hd) begin
        pe = $urandom_range(0, 9) < 7;
        pd = 5'($urandom_range(0, 15) == 0 ? 0 : $urandom_range(1, 31));
        pdat = $urandom;
      end
      if (!(mv && !acc)) begin
        mv = $urandom_range(0, 9) < 4;
        md = 5'($urandom_range(0, 31));
        mdat = $urandom;
      end
      r = $urandom_range(0, 199) == 0;
      cyc(r, pe, pd, pdat, mv, md, mdat, $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), acc, hd);
    end
    idle(6);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
